ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_rx_frame.sv | 118 +++++++++++
 rtl/ps2_key_decoder.sv | 94 +++++++++
 tb/tb_ps2_key_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: scan codes, frame length and the key decoder state enum.
package ps2_pkg;

  localparam int FRAME_LEN = 11;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit framing, checks, idle timeout.
// Parity checking is compiled in only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   valid_q, valid_d;
  logic [7:0]             byte_q, byte_d;
  logic                   err_q, err_d;
  logic                   fall;
  logic                   data_s;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    data_s      = data_sync_q[SYNC_STAGES-1];
    fall        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    valid_d     = 1'b0;
    byte_d      = byte_q;
    err_d       = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (cnt_q == 4'd0) begin
        // A high start bit is line noise, not a frame: stay idle silently.
        if (!data_s) begin
          cnt_d = 4'd1;
          par_d = 1'b0;
        end
      end else if (cnt_q == LAST_BIT) begin
        cnt_d = 4'd0;
        if (data_s && (par_q || !PAR_EN)) begin
          valid_d = 1'b1;
          byte_d  = shift_q;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
        par_d = par_q ^ data_s;
        if (cnt_q <= 4'd8) shift_d = {data_s, shift_q[7:1]};
      end
    end else if (cnt_q != 4'd0) begin
      if (tmo_q == TMO_MAX) begin
        cnt_d = 4'd0;
        tmo_d = '0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Synchronizers reset to the idle-high bus level so release never fakes an edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      valid_q     <= 1'b0;
      byte_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      err_q       <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign data_byte  = byte_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 arrow-key decoder: extended make codes E0 6B/74/75/72 give one-cycle left/right/up/down pulses.
// Build option PS2_PARITY_CHECK_EN enables parity checking in the frame receiver.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic left,
  output logic right,
  output logic up,
  output logic down,
  output logic frame_err
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .data_byte (rx_byte),
    .frame_err (rx_err)
  );

  dec_state_e state_q, state_d;
  logic       left_q, left_d, right_q, right_d, up_q, up_d, down_q, down_d;

  always_comb begin
    state_d = state_q;
    left_d  = 1'b0;
    right_d = 1'b0;
    up_d    = 1'b0;
    down_d  = 1'b0;
    if (rx_err) begin
      state_d = IDLE;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_byte == SC_EXT)      state_d = EXT;
          else if (rx_byte == SC_BRK) state_d = BRK;
          else                        state_d = IDLE;
        end
        EXT: begin
          // A repeated E0 keeps the prefix armed; anything else ends the sequence.
          if (rx_byte == SC_BRK)      state_d = EXT_BRK;
          else if (rx_byte == SC_EXT) state_d = EXT;
          else begin
            state_d = IDLE;
            left_d  = (rx_byte == SC_LEFT);
            right_d = (rx_byte == SC_RIGHT);
            up_d    = (rx_byte == SC_UP);
            down_d  = (rx_byte == SC_DOWN);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign up        = up_q;
  assign down      = down_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: frame driver tasks, expected-pulse queue, final report.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 1000;
  localparam int H    = 20;
  localparam int W    = 5;

  localparam logic [W-1:0] P_ERR   = 5'b10000;
  localparam logic [W-1:0] P_LEFT  = 5'b01000;
  localparam logic [W-1:0] P_RIGHT = 5'b00100;
  localparam logic [W-1:0] P_UP    = 5'b00010;
  localparam logic [W-1:0] P_DOWN  = 5'b00001;

  logic clk, clrn, ps2_clk, ps2_data;
  logic left, right, up, down, frame_err;
  logic [W-1:0] outs;
  logic [W-1:0] exp_q[$];
  int checks, failures;

  assign outs = {frame_err, left, right, up, down};

  ps2_key_decoder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .left     (left),
    .right    (right),
    .up       (up),
    .down     (down),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Any nonzero output cycle must match the next expected pulse.
  always @(negedge clk) begin
    if (clrn && outs != '0) begin
      if (exp_q.size() == 0) check_eq("unexpected_pulse", 16'(outs), 16'h0);
      else                   check_eq("pulse", 16'(outs), 16'(exp_q.pop_front()));
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit lat_chk, input logic [W-1:0] lat_exp);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (lat_chk && i == 10) begin
        repeat (3) @(posedge clk);
        #1 check_eq("lat_before", 16'(outs), 16'h0);
        @(posedge clk);
        #1 check_eq("lat_pulse", 16'(outs), 16'(lat_exp));
        @(posedge clk);
        #1 check_eq("lat_after", 16'(outs), 16'h0);
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0, '0);
  endtask

  logic [7:0]   arrow_sc [4];
  logic [W-1:0] arrow_p  [4];

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench exceeded cycle budget, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    arrow_sc = '{SC_LEFT, SC_RIGHT, SC_UP, SC_DOWN};
    arrow_p  = '{P_LEFT, P_RIGHT, P_UP, P_DOWN};
    checks = 0;
    failures = 0;
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("reset_outs", 16'(outs), 16'h0);
    clrn = 1'b1;
    @(posedge clk);
    #1 check_eq("post_reset_outs", 16'(outs), 16'h0);
    repeat (5) @(negedge clk);

    // E0 6B -> left, with exact latency after the stop-bit edge
    send_byte(SC_EXT);
    exp_q.push_back(P_LEFT);
    send_frame(SC_LEFT, 1'b0, 11, 1'b1, P_LEFT);

    // Extended break then extended make of right arrow
    send_byte(SC_EXT);
    send_byte(SC_BRK);
    send_byte(SC_RIGHT);
    check_eq("state_after_break", 16'(dut.state_q), 16'(IDLE));
    send_byte(SC_EXT);
    exp_q.push_back(P_RIGHT);
    send_byte(SC_RIGHT);

    // Bad parity on 0x75
`ifdef PS2_PARITY_CHECK_EN
    exp_q.push_back(P_ERR);
`endif
    send_frame(SC_UP, 1'b1, 11, 1'b0, '0);

    // Partial frame then idle clock -> timeout error
    exp_q.push_back(P_ERR);
    send_frame(SC_EXT, 1'b0, 5, 1'b0, '0);
    repeat (TMO + 20) @(negedge clk);
    check_eq("timeout_drained", 16'(exp_q.size()), 16'h0);
    send_byte(SC_EXT);
    exp_q.push_back(P_DOWN);
    send_byte(SC_DOWN);

    // Reset mid-frame, then a clean E0 75
    send_frame(SC_EXT, 1'b0, 6, 1'b0, '0);
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midframe_reset_outs", 16'(outs), 16'h0);
    clrn = 1'b1;
    @(posedge clk);
    #1 check_eq("midframe_release_outs", 16'(outs), 16'h0);
    repeat (4) @(negedge clk);
    send_byte(SC_EXT);
    exp_q.push_back(P_UP);
    send_byte(SC_UP);

    // Keypad 72 alone, then typematic E0 6B E0 6B
    send_byte(SC_DOWN);
    for (int i = 0; i < 2; i++) begin
      send_byte(SC_EXT);
      exp_q.push_back(P_LEFT);
      send_byte(SC_LEFT);
    end

    // Random arrow make codes
    for (int i = 0; i < 4; i++) begin
      int k;
      k = $urandom_range(0, 3);
      send_byte(SC_EXT);
      exp_q.push_back(arrow_p[k]);
      send_byte(arrow_sc[k]);
    end

    repeat (20) @(negedge clk);
    check_eq("queue_empty", 16'(exp_q.size()), 16'h0);
    check_eq("final_state", 16'(dut.state_q), 16'(IDLE));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
